envelope_amplifier: RTL and testbench
=====================================

// Module: envelope_amplifier
// PURPOSE
//   ADSR envelope generator plus amplitude stage directly downstream of the sine LUT tone generator.
//   Takes the LUT's unsigned offset-binary sample each sample tick and converts it to signed.
//   Scales it by an envelope level driven by a note gate; emits a registered signed sample with valid strobe.
//   Feeds the mixer / DAC output stage.
// PARAMETERS
//   SAMPLE_BITS   16  width of din (offset-binary) and dout (two's complement)
//   ENV_ACC_BITS  16  envelope accumulator width; level = acc[MSB -: ENV_BITS]
//   ENV_BITS       8  envelope level width (gain = level/2^ENV_BITS)
//   RATE_SHIFT     4  per-tick step = rate << RATE_SHIFT (zero-extended to ENV_ACC_BITS)
// PORTS
//   clk           in   1            system clock
//   rst_n         in   1            synchronous reset, active low
//   sample_strobe in   1            one-cycle pulse per audio sample
//   gate          in   1            note held (sampled only on sample_strobe)
//   attack        in   8            attack rate
//   decay         in   8            decay rate
//   sustain       in   ENV_BITS     sustain level
//   release       in   8            release rate
//   din           in   SAMPLE_BITS  LUT sample, offset-binary
//   dout          out  SAMPLE_BITS  signed amplified sample
//   dout_valid    out  1            one-cycle pulse, dout new
//   env_level     out  ENV_BITS     current envelope level
//   active        out  1            state != IDLE
// BEHAVIOUR
//   Reset: one clock with rst_n low -> state IDLE, acc=0; dout, dout_valid, env_level, active = 0; pipeline flushed.
//   Reset mid-note or mid-pipeline: same; in-flight samples dropped, no dout_valid.
//   FSM advances only on sample_strobe. Gate check takes priority over the rate step.
//   IDLE:    gate=1 -> ATTACK (acc unchanged this tick).
//   ATTACK:  gate=0 -> RELEASE; else acc += step(attack), saturating at all-ones.
//            Hitting all-ones -> DECAY.
//   DECAY:   gate=0 -> RELEASE; else acc -= step(decay). If result <= {sustain,0..}, clamp acc={sustain,0..} -> SUSTAIN.
//   SUSTAIN: gate=0 -> RELEASE; else acc = {sustain,0..} (tracks live sustain changes).
//   RELEASE: gate=1 -> ATTACK from current acc (no reset to 0); else acc -= step(release), saturating at 0.
//            Hitting 0 -> IDLE.
//   Rate 0 -> step 0 -> envelope stalls in that state (legal, not an error).
//   Datapath, one sample per clock max (strobes may be back-to-back):
//     edge of strobe cycle N: s1 <= {~din[MSB], din[MSB-1:0]}; envelope updates.
//     N+1: prod <= s1 * $signed({1'b0, env_level}), using the level after cycle-N update.
//     N+2: dout <= prod >>> ENV_BITS (arithmetic shift, truncate); dout_valid=1 for exactly one cycle.
//   Latency sample_strobe -> dout_valid = 2 clocks. dout holds between valids.
//   Product width SAMPLE_BITS+ENV_BITS+1; no overflow possible since |gain| < 1.
// CONFIGURATION
//   ENV_AMP_VELOCITY_EN defined: extra port velocity[ENV_BITS-1:0].
//     Latched on the strobe where IDLE/RELEASE -> ATTACK.
//     Attack peak becomes {velocity, all-ones}; hitting peak -> DECAY.
//     Effective sustain = min(sustain, latched velocity).
//   Undefined: no port; peak = all-ones; sustain used directly.
// STRUCTURE
//   Package envelope_amplifier_pkg: env_state_t enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE).
//     Also default widths and a step() constant function.
//   Sub-module envelope_generator: FSM + accumulator; outputs env_level and active.
//   The top holds the 2-stage amplify pipeline.
// TESTING
//   Reset: rst_n low 1 cycle mid-ATTACK -> dout=0, dout_valid=0, active=0, env_level=0 next cycle.
//   Attack: attack=0x10, gate=1, strobe every 4 clks -> DECAY entered on 257th strobe (1 transition + 256 steps).
//     env_level=0xFF on reaching peak.
//   Decay/sustain: decay=0x10, sustain=0x80 -> SUSTAIN after 128 decay strobes.
//     env_level=0x80, acc=0x8000 exact.
//   Amplify at level 0x80: din=0xFFFF -> dout=0x3FFF; din=0x0000 -> dout=0xC000.
//     din=0x8000 -> dout=0x0000; each valid 2 clks after strobe.
//   Release/retrigger: gate=0 at level 0x80, release=0x10 -> IDLE after 1+128 strobes.
//     gate=1 again at level 0x40 -> ATTACK resumes from 0x4000.
//   Back-to-back strobes for 8 cycles -> 8 dout_valid pulses, contiguous, in order.

Source files
------------

// File: rtl/envelope_amplifier_pkg.sv
// Shared types, default widths and rate-step helper for the envelope amplifier.
package envelope_amplifier_pkg;

  localparam int DEF_SAMPLE_BITS  = 16;
  localparam int DEF_ENV_ACC_BITS = 16;
  localparam int DEF_ENV_BITS     = 8;
  localparam int DEF_RATE_SHIFT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  // Per-tick accumulator step; callers truncate to the accumulator width.
  function automatic logic [31:0] env_step(input logic [7:0] rate, input int shift);
    return {24'd0, rate} << shift;
  endfunction

endpackage

// File: rtl/envelope_generator.sv
// ADSR state machine and envelope accumulator, advancing once per sample strobe.
// ENV_AMP_VELOCITY_EN adds a velocity input that caps the attack peak and sustain level.
module envelope_generator
  import envelope_amplifier_pkg::*;
#(
  parameter int ENV_ACC_BITS = DEF_ENV_ACC_BITS,
  parameter int ENV_BITS     = DEF_ENV_BITS,
  parameter int RATE_SHIFT   = DEF_RATE_SHIFT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic                gate,
  input  logic [7:0]          attack,
  input  logic [7:0]          decay,
  input  logic [ENV_BITS-1:0] sustain,
  input  logic [7:0]          release_rate,
`ifdef ENV_AMP_VELOCITY_EN
  input  logic [ENV_BITS-1:0] velocity,
`endif
  output logic [ENV_BITS-1:0] env_level,
  output logic                active
);

  localparam int LOW_BITS = ENV_ACC_BITS - ENV_BITS;

  env_state_t state, state_nxt;
  logic [ENV_ACC_BITS-1:0] acc, acc_nxt;
  logic [ENV_ACC_BITS-1:0] peak, sus_acc;
  logic [ENV_ACC_BITS-1:0] step_a, step_d, step_r;
  logic [ENV_ACC_BITS:0]   sum_a, dif_d, dif_r;
  logic [ENV_BITS-1:0]     sus_eff;

`ifdef ENV_AMP_VELOCITY_EN
  logic [ENV_BITS-1:0] vel_q, vel_nxt;
  assign peak    = {vel_q, {LOW_BITS{1'b1}}};
  assign sus_eff = (sustain < vel_q) ? sustain : vel_q;
`else
  assign peak    = {ENV_ACC_BITS{1'b1}};
  assign sus_eff = sustain;
`endif

  assign sus_acc = {sus_eff, {LOW_BITS{1'b0}}};
  assign step_a  = ENV_ACC_BITS'(env_step(attack, RATE_SHIFT));
  assign step_d  = ENV_ACC_BITS'(env_step(decay, RATE_SHIFT));
  assign step_r  = ENV_ACC_BITS'(env_step(release_rate, RATE_SHIFT));

  // One extra bit catches carry (attack) and borrow (decay/release) for saturation.
  assign sum_a = {1'b0, acc} + {1'b0, step_a};
  assign dif_d = {1'b0, acc} - {1'b0, step_d};
  assign dif_r = {1'b0, acc} - {1'b0, step_r};

  // Next-state and accumulator decode; the gate check wins over the rate step.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
`ifdef ENV_AMP_VELOCITY_EN
    vel_nxt   = vel_q;
`endif
    if (sample_strobe) begin
      case (state)
        ST_IDLE: begin
          if (gate) begin
            state_nxt = ST_ATTACK;
`ifdef ENV_AMP_VELOCITY_EN
            vel_nxt   = velocity;
`endif
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_ATTACK: begin
          if (!gate) begin
            state_nxt = ST_RELEASE;
          end else if (sum_a[ENV_ACC_BITS] || (sum_a[ENV_ACC_BITS-1:0] >= peak)) begin
            acc_nxt   = peak;
            state_nxt = ST_DECAY;
          end else begin
            acc_nxt   = sum_a[ENV_ACC_BITS-1:0];
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            state_nxt = ST_RELEASE;
          end else if (dif_d[ENV_ACC_BITS] || (dif_d[ENV_ACC_BITS-1:0] <= sus_acc)) begin
            acc_nxt   = sus_acc;
            state_nxt = ST_SUSTAIN;
          end else begin
            acc_nxt   = dif_d[ENV_ACC_BITS-1:0];
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            state_nxt = ST_RELEASE;
          end else begin
            acc_nxt   = sus_acc;
          end
        end
        ST_RELEASE: begin
          if (gate) begin
            state_nxt = ST_ATTACK;
`ifdef ENV_AMP_VELOCITY_EN
            vel_nxt   = velocity;
`endif
          end else if (dif_r[ENV_ACC_BITS] || (dif_r[ENV_ACC_BITS-1:0] == {ENV_ACC_BITS{1'b0}})) begin
            acc_nxt   = {ENV_ACC_BITS{1'b0}};
            state_nxt = ST_IDLE;
          end else begin
            acc_nxt   = dif_r[ENV_ACC_BITS-1:0];
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          acc_nxt   = {ENV_ACC_BITS{1'b0}};
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // State, accumulator and activity flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      acc    <= {ENV_ACC_BITS{1'b0}};
      active <= 1'b0;
`ifdef ENV_AMP_VELOCITY_EN
      vel_q  <= {ENV_BITS{1'b0}};
`endif
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      active <= (state_nxt != ST_IDLE);
`ifdef ENV_AMP_VELOCITY_EN
      vel_q  <= vel_nxt;
`endif
    end
  end

  assign env_level = acc[ENV_ACC_BITS-1 -: ENV_BITS];

endmodule

// File: rtl/envelope_amplifier.sv
// ADSR envelope plus two-stage signed amplify pipeline for offset-binary LUT samples.
// ENV_AMP_VELOCITY_EN adds the velocity port passed to the envelope generator.
module envelope_amplifier
  import envelope_amplifier_pkg::*;
#(
  parameter int SAMPLE_BITS  = DEF_SAMPLE_BITS,
  parameter int ENV_ACC_BITS = DEF_ENV_ACC_BITS,
  parameter int ENV_BITS     = DEF_ENV_BITS,
  parameter int RATE_SHIFT   = DEF_RATE_SHIFT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_strobe,
  input  logic                   gate,
  input  logic [7:0]             attack,
  input  logic [7:0]             decay,
  input  logic [ENV_BITS-1:0]    sustain,
  input  logic [7:0]             release_rate,
`ifdef ENV_AMP_VELOCITY_EN
  input  logic [ENV_BITS-1:0]    velocity,
`endif
  input  logic [SAMPLE_BITS-1:0] din,
  output logic [SAMPLE_BITS-1:0] dout,
  output logic                   dout_valid,
  output logic [ENV_BITS-1:0]    env_level,
  output logic                   active
);

  localparam int PROD_BITS = SAMPLE_BITS + ENV_BITS + 1;

  logic signed [SAMPLE_BITS-1:0] s1;
  logic signed [PROD_BITS-1:0]   s1_ext, gain_ext, prod;
  logic                          v1, v2;

  envelope_generator #(
    .ENV_ACC_BITS (ENV_ACC_BITS),
    .ENV_BITS     (ENV_BITS),
    .RATE_SHIFT   (RATE_SHIFT)
  ) u_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .gate          (gate),
    .attack        (attack),
    .decay         (decay),
    .sustain       (sustain),
    .release_rate  (release_rate),
`ifdef ENV_AMP_VELOCITY_EN
    .velocity      (velocity),
`endif
    .env_level     (env_level),
    .active        (active)
  );

  // Gain is a non-negative fraction, so the full product never overflows PROD_BITS.
  assign s1_ext   = {{(ENV_BITS+1){s1[SAMPLE_BITS-1]}}, s1};
  assign gain_ext = {{(SAMPLE_BITS+1){1'b0}}, env_level};

  // Convert, scale, shift: each stage fires only when its valid is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= '0;
      prod       <= '0;
      dout       <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      v1         <= sample_strobe;
      v2         <= v1;
      dout_valid <= v2;
      if (sample_strobe) begin
        s1 <= $signed({~din[SAMPLE_BITS-1], din[SAMPLE_BITS-2:0]});
      end
      if (v1) begin
        prod <= s1_ext * gain_ext;
      end
      if (v2) begin
        dout <= SAMPLE_BITS'(prod >>> ENV_BITS);
      end
    end
  end

endmodule

// File: tb/tb_envelope_amplifier.sv
// Directed table-driven bench for envelope_amplifier: ADSR walk, amplify vectors, latency, reset.
module tb_envelope_amplifier;
  import envelope_amplifier_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, sample_strobe, gate;
  logic [7:0]  attack, decay, sustain, release_rate;
  logic [15:0] din, dout;
  logic        dout_valid, active;
  logic [7:0]  env_level;
`ifdef ENV_AMP_VELOCITY_EN
  logic [7:0]  velocity = 8'hFF;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
  } amp_vec_t;
  amp_vec_t vecs[7];

  envelope_amplifier dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .gate          (gate),
    .attack        (attack),
    .decay         (decay),
    .sustain       (sustain),
    .release_rate  (release_rate),
`ifdef ENV_AMP_VELOCITY_EN
    .velocity      (velocity),
`endif
    .din           (din),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .env_level     (env_level),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); sample_strobe = 1'b1;
      @(negedge clk); sample_strobe = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.u_gen.state);
  endfunction

  function automatic logic [31:0] acc();
    return 32'(dut.u_gen.acc);
  endfunction

  initial begin
    int n;
    int got, first_c, last_c;

    // din -> dout at envelope level 0x80 (gain 1/2)
    vecs[0] = '{16'hFFFF, 16'h3FFF};
    vecs[1] = '{16'h0000, 16'hC000};
    vecs[2] = '{16'h8000, 16'h0000};
    vecs[3] = '{16'hC000, 16'h2000};
    vecs[4] = '{16'h4000, 16'hE000};
    vecs[5] = '{16'h8001, 16'h0000};
    vecs[6] = '{16'h7FFF, 16'hFFFF};

    rst_n = 1'b0; sample_strobe = 1'b0; gate = 1'b0;
    attack = 8'h10; decay = 8'h10; sustain = 8'h80; release_rate = 8'h10;
    din = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_level", 32'(env_level), 32'h0);

    // Attack: 1 transition strobe + 256 steps of 0x100
    gate = 1'b1;
    run_strobes(1);
    check("atk_enter_state", st(), 32'(ST_ATTACK));
    check("atk_enter_acc", acc(), 32'h0);
    check("atk_active", 32'(active), 32'h1);
    run_strobes(255);
    check("atk_256_state", st(), 32'(ST_ATTACK));
    check("atk_256_acc", acc(), 32'hFF00);
    check("atk_256_level", 32'(env_level), 32'hFF);
    run_strobes(1);
    check("atk_257_state", st(), 32'(ST_DECAY));
    check("atk_257_acc", acc(), 32'hFFFF);
    check("atk_257_level", 32'(env_level), 32'hFF);

    // Decay to sustain 0x80 in 128 strobes
    run_strobes(127);
    check("dec_127_state", st(), 32'(ST_DECAY));
    check("dec_127_acc", acc(), 32'h80FF);
    run_strobes(1);
    check("dec_128_state", st(), 32'(ST_SUSTAIN));
    check("dec_128_acc", acc(), 32'h8000);
    check("dec_128_level", 32'(env_level), 32'h80);

    // Amplify table with latency and single-pulse checks
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); sample_strobe = 1'b1; din = vecs[i].din;
      @(negedge clk); sample_strobe = 1'b0;
      check("amp_lat1_valid", 32'(dout_valid), 32'h0);
      @(negedge clk);
      check("amp_lat2_valid", 32'(dout_valid), 32'h0);
      @(negedge clk);
      check("amp_valid", 32'(dout_valid), 32'h1);
      check("amp_dout", 32'(dout), 32'(vecs[i].dout));
      @(negedge clk);
      check("amp_pulse_end", 32'(dout_valid), 32'h0);
      check("amp_dout_hold", 32'(dout), 32'(vecs[i].dout));
    end

    // Back-to-back strobes: 8 contiguous valids in order
    got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (dout_valid) begin
        if (got < 8) check("b2b_dout", 32'(dout), 32'(vecs[got % 7].dout));
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (c < 8) begin
        sample_strobe = 1'b1; din = vecs[c % 7].din;
      end else begin
        sample_strobe = 1'b0;
      end
    end
    check("b2b_count", 32'(got), 32'd8);
    check("b2b_first", 32'(first_c), 32'd3);
    check("b2b_contig", 32'(last_c - first_c), 32'd7);

    // Release then retrigger at level 0x40
    gate = 1'b0;
    run_strobes(1);
    check("rel_enter_state", st(), 32'(ST_RELEASE));
    check("rel_enter_acc", acc(), 32'h8000);
    run_strobes(64);
    check("rel_64_level", 32'(env_level), 32'h40);
    gate = 1'b1;
    run_strobes(1);
    check("retrig_state", st(), 32'(ST_ATTACK));
    check("retrig_acc", acc(), 32'h4000);
    run_strobes(1);
    check("retrig_step_acc", acc(), 32'h4100);

    // Back up to sustain (bounded), then full release 1+128 strobes to IDLE
    n = 0;
    while (st() != 32'(ST_SUSTAIN) && n < 400) begin
      run_strobes(1); n++;
    end
    check("resustain_state", st(), 32'(ST_SUSTAIN));
    check("resustain_acc", acc(), 32'h8000);
    gate = 1'b0;
    run_strobes(128);
    check("rel_128_state", st(), 32'(ST_RELEASE));
    check("rel_128_acc", acc(), 32'h0100);
    check("rel_128_active", 32'(active), 32'h1);
    run_strobes(1);
    check("rel_129_state", st(), 32'(ST_IDLE));
    check("rel_129_acc", acc(), 32'h0);
    check("rel_129_active", 32'(active), 32'h0);

    // Zero attack rate stalls in ATTACK
    attack = 8'h00; gate = 1'b1;
    run_strobes(4);
    check("stall_state", st(), 32'(ST_ATTACK));
    check("stall_acc", acc(), 32'h0);

    // Reset mid-attack with a sample in flight
    attack = 8'h10;
    run_strobes(10);
    check("pre_rst_level", 32'(env_level), 32'h0A);
    @(negedge clk); sample_strobe = 1'b1; din = 16'hFFFF;
    @(negedge clk); sample_strobe = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("mid_rst_dout", 32'(dout), 32'h0);
    check("mid_rst_valid", 32'(dout_valid), 32'h0);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_level", 32'(env_level), 32'h0);
    got = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dout_valid) got++;
    end
    check("mid_rst_flushed", 32'(got), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
